aes_uart_host: RTL and testbench

- Host-side counterpart of the masked-AES chip's UART link.
- Serialises a 128-bit key and a 128-bit plaintext onto the chip's rx pin.
- Then deserialises the 16-byte ciphertext the chip returns on its tx pin.
- Lives in the FPGA/bench harness that drives the taped-out chip; also used as the reference driver in chip-level simulation.

---
 rtl/aes_uart_host_pkg.sv | 7 +
 rtl/aes_uart_host_rx.sv | 92 +++++++++
 rtl/aes_uart_host.sv | 155 +++++++++++++++
 tb/tb_aes_uart_host.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_uart_host_pkg.sv
// aes_uart_host_pkg: shared FSM state type and frame-size constants for the host UART link
package aes_uart_host_pkg;
    typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_e;
    localparam int TX_BYTES       = 32;
    localparam int RX_BYTES       = 16;
    localparam int UART_DATA_BITS = 8;
endpackage

// File: rtl/aes_uart_host_rx.sv
// uart_rx_byte: 8N1 byte receiver with mid-bit sampling and start-glitch rejection
//   io_clk, io_reset : clock, synchronous active-high reset
//   enable           : low holds the receiver in its hunt state
//   rx               : already-synchronised serial line
//   byte_valid       : one-cycle pulse with data on a good stop bit
//   data             : last received byte
//   stop_err         : one-cycle pulse on a stop bit sampled low
//   rx_active        : high from start-bit detection until the frame ends
module uart_rx_byte
    import aes_uart_host_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       io_clk,
    input  logic       io_reset,
    input  logic       enable,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] data,
    output logic       stop_err,
    output logic       rx_active
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] FULL_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [3:0] STOP_BIT = 4'(UART_DATA_BITS + 1);

    logic          prev_q, active_q, active_d, valid_q, valid_d, err_q, err_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    data_q, data_d;
    logic          sample;

    // bit 0 is the start bit, checked half a bit in; later bits one full bit apart
    assign sample = active_q && cnt_q == ((bit_q == 4'd0) ? HALF_LAST : FULL_LAST);

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q + BW'(1);
        bit_d    = bit_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        if (!enable)
            active_d = 1'b0;
        else if (!active_q) begin
            if (prev_q && !rx) begin
                active_d = 1'b1;
                cnt_d    = '0;
                bit_d    = '0;
            end
        end else if (sample) begin
            cnt_d = '0;
            if (bit_q == 4'd0) begin
                active_d = !rx;
                bit_d    = 4'd1;
            end else if (bit_q == STOP_BIT) begin
                active_d = 1'b0;
                valid_d  = rx;
                err_d    = !rx;
            end else begin
                data_d = {rx, data_q[7:1]};
                bit_d  = bit_q + 4'd1;
            end
        end
    end

    always_ff @(posedge io_clk) begin
        if (io_reset) begin
            prev_q   <= 1'b1;
            active_q <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            bit_q    <= '0;
            data_q   <= '0;
        end else begin
            prev_q   <= rx;
            active_q <= active_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
        end
    end

    assign byte_valid = valid_q;
    assign stop_err   = err_q;
    assign data       = data_q;
    assign rx_active  = active_q;
endmodule

// File: rtl/aes_uart_host.sv
// aes_uart_host: sends key+plaintext over UART to the AES chip and collects the 16-byte ciphertext
//   io_clk, io_reset        : clock, synchronous active-high reset
//   start, key, plaintext   : request and the 256-bit block captured with it
//   io_tx / io_rx / io_done : chip pads (rx and done are asynchronous)
//   busy, result_valid, ciphertext, timeout, frame_err, chip_done : status and result
module aes_uart_host
    import aes_uart_host_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 868,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic         io_clk,
    input  logic         io_reset,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] plaintext,
    output logic         io_tx,
    input  logic         io_rx,
    input  logic         io_done,
    output logic         busy,
    output logic         result_valid,
    output logic [127:0] ciphertext,
    output logic         timeout,
    output logic         frame_err,
    output logic         chip_done
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]    TX_LAST   = 5'(TX_BYTES - 1);
    localparam logic [3:0]    RX_LAST   = 4'(RX_BYTES - 1);
    localparam logic [3:0]    STOP_BIT  = 4'(UART_DATA_BITS + 1);

    state_e         state_q, state_d;
    logic [255:0]   sh_q, sh_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic [3:0]     bit_q, bit_d;
    logic [4:0]     tbyte_q, tbyte_d;
    logic [3:0]     rbyte_q, rbyte_d;
    logic [TW-1:0]  to_q, to_d;
    logic [127:0]   ct_q, ct_d;
    logic           tx_q, tx_d, timeout_q, timeout_d, ferr_q, ferr_d;
    logic [1:0]     rx_sync_q, done_sync_q;
    logic [7:0]     tx_byte, rx_data;
    logic           rx_valid, rx_err, rx_active;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .io_clk     (io_clk),
        .io_reset   (io_reset),
        .enable     (state_q == RECV),
        .rx         (rx_sync_q[1]),
        .byte_valid (rx_valid),
        .data       (rx_data),
        .stop_err   (rx_err),
        .rx_active  (rx_active)
    );

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        tbyte_d   = tbyte_q;
        rbyte_d   = rbyte_q;
        to_d      = to_q;
        ct_d      = ct_q;
        timeout_d = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = SEND;
                sh_d    = {key, plaintext};
                baud_d  = '0;
                bit_d   = '0;
                tbyte_d = '0;
            end
            SEND: begin
                baud_d = (baud_q == BAUD_LAST) ? '0 : baud_q + BW'(1);
                if (baud_q == BAUD_LAST) begin
                    bit_d = (bit_q == STOP_BIT) ? '0 : bit_q + 4'd1;
                    if (bit_q == STOP_BIT) begin
                        sh_d    = sh_q << 8;
                        tbyte_d = tbyte_q + 5'd1;
                        if (tbyte_q == TX_LAST) begin
                            state_d = RECV;
                            rbyte_d = '0;
                            to_d    = '0;
                        end
                    end
                end
            end
            RECV: begin
                to_d = rx_active ? '0 : to_q + TW'(1);
                if (rx_err) begin
                    ferr_d  = 1'b1;
                    state_d = IDLE;
                end else if (rx_valid) begin
                    // byte n lands at bits [127-8n -: 8]; ~n*8 is that slice's base
                    ct_d[{~rbyte_q, 3'b000} +: 8] = rx_data;
                    rbyte_d = rbyte_q + 4'd1;
                    state_d = (rbyte_q == RX_LAST) ? DONE : RECV;
                end else if (!rx_active && to_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // line level is derived from next-state so the pad is driven from a flop without lag
        tx_byte = sh_d[255:248];
        tx_d = (state_d != SEND || bit_d == STOP_BIT) ? 1'b1 :
               (bit_d == 4'd0) ? 1'b0 : tx_byte[3'(bit_d - 4'd1)];
    end

    always_ff @(posedge io_clk) begin
        if (io_reset) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            baud_q      <= '0;
            bit_q       <= '0;
            tbyte_q     <= '0;
            rbyte_q     <= '0;
            to_q        <= '0;
            ct_q        <= '0;
            tx_q        <= 1'b1;
            timeout_q   <= 1'b0;
            ferr_q      <= 1'b0;
            rx_sync_q   <= 2'b11;
            done_sync_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            tbyte_q     <= tbyte_d;
            rbyte_q     <= rbyte_d;
            to_q        <= to_d;
            ct_q        <= ct_d;
            tx_q        <= tx_d;
            timeout_q   <= timeout_d;
            ferr_q      <= ferr_d;
            rx_sync_q   <= {rx_sync_q[0], io_rx};
            done_sync_q <= {done_sync_q[0], io_done};
        end
    end

    assign io_tx        = tx_q;
    assign busy         = state_q != IDLE;
    assign result_valid = state_q == DONE;
    assign ciphertext   = ct_q;
    assign timeout      = timeout_q;
    assign frame_err    = ferr_q;
    assign chip_done    = done_sync_q[1];
endmodule

// File: tb/tb_aes_uart_host.sv
// tb_aes_uart_host: directed/random exchanges against a behavioural model of the chip's UART link
module tb_aes_uart_host;
    localparam int CPB = 8;
    localparam int TO  = 1000;

    logic         io_clk = 1'b0, io_reset = 1'b1, start = 1'b0, io_rx = 1'b1, io_done = 1'b0;
    logic [127:0] key = '0, plaintext = '0, ciphertext;
    logic         io_tx, busy, result_valid, timeout, frame_err, chip_done;
    int           tests = 0, fails = 0, cyc = 0, rv_cnt = 0, to_cnt = 0, fe_cnt = 0, t_send0 = 0;

    aes_uart_host #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TO)) dut (
        .io_clk(io_clk), .io_reset(io_reset), .start(start), .key(key), .plaintext(plaintext),
        .io_tx(io_tx), .io_rx(io_rx), .io_done(io_done), .busy(busy), .result_valid(result_valid),
        .ciphertext(ciphertext), .timeout(timeout), .frame_err(frame_err), .chip_done(chip_done)
    );

    always #5 io_clk = ~io_clk;
    always @(posedge io_clk) cyc <= cyc + 1;
    always @(negedge io_clk) begin
        if (result_valid === 1'b1) rv_cnt <= rv_cnt + 1;
        if (timeout === 1'b1) to_cnt <= to_cnt + 1;
        if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // pulses start, then checks every io_tx cycle of the 32-byte frame against the ideal 8N1 waveform
    task automatic do_send(input logic [127:0] k, input logic [127:0] p, input bit poke);
        logic [255:0] blk;
        logic [7:0]   b;
        logic         e;
        int           n, bad, bi;
        blk = {k, p};
        key = k;
        plaintext = p;
        @(negedge io_clk) start = 1'b1;
        @(negedge io_clk) start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            n = 0;
            while (io_tx !== 1'b0 && n < 40 * CPB) begin
                @(negedge io_clk);
                n++;
            end
            if (i == 0) t_send0 = cyc;
            chk($sformatf("tx_gap%0d", i), n, 0);
            b = 8'(blk >> (8 * (31 - i)));
            bad = 0;
            for (int j = 0; j < 10 * CPB; j++) begin
                bi = j / CPB;
                e = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b[bi-1];
                if (io_tx !== e) bad++;
                if (poke && i == 5 && j == 3) begin
                    start = 1'b1;
                    key = ~k;
                    plaintext = ~p;
                end
                if (poke && i == 5 && j == 4) start = 1'b0;
                @(negedge io_clk);
            end
            chk($sformatf("tx_b%0d_badcycles", i), bad, 0);
        end
    endtask

    task automatic send_bit(input logic v);
        io_rx = v;
        repeat (CPB) @(negedge io_clk);
    endtask

    // chip model: after 100 bit-times, returns ct MSB byte first; byte `bad` gets a low stop bit and ends the reply
    task automatic do_reply(input logic [127:0] ct, input int bad);
        logic [7:0] b;
        int last;
        last = (bad < 0) ? 15 : bad;
        repeat (100 * CPB) @(negedge io_clk);
        for (int i = 0; i <= last; i++) begin
            b = 8'(ct >> (8 * (15 - i)));
            send_bit(1'b0);
            for (int j = 0; j < 8; j++) send_bit(b[j]);
            send_bit(i != bad);
        end
        io_rx = 1'b1;
        repeat (4) @(negedge io_clk);
    endtask

    initial begin
        logic [127:0] ct, prev;
        int rv0, fe0, to0, n;
        repeat (3) @(negedge io_clk);
        chk("rst_tx", io_tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_to", timeout, 0);
        chk("rst_fe", frame_err, 0);
        chk("rst_ct", ciphertext, 0);
        chk("rst_cd", chip_done, 0);
        io_reset = 1'b0;

        io_done = 1'b1;
        @(negedge io_clk);
        chk("cd_lat1", chip_done, 0);
        @(negedge io_clk);
        chk("cd_lat2", chip_done, 1);
        io_done = 1'b0;

        rv0 = rv_cnt;
        do_send(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff, 1'b0);
        do_reply(128'h69c4e0d86a7b0430d8cdb78070b4c55a, -1);
        chk("fips_ct", ciphertext, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        chk("fips_rv", rv_cnt - rv0, 1);
        chk("fips_busy", busy, 0);

        rv0 = rv_cnt;
        to0 = to_cnt;
        do_send(rnd128(), rnd128(), 1'b0);
        n = 0;
        while (timeout !== 1'b1 && n < TO + 100) begin
            @(negedge io_clk);
            n++;
        end
        chk("to_latency", cyc - t_send0, 320 * CPB + TO);
        chk("to_busy", busy, 0);
        @(negedge io_clk);
        chk("to_pulse_len", timeout, 0);
        chk("to_count", to_cnt - to0, 1);
        chk("to_rv", rv_cnt - rv0, 0);
        chk("to_ct_hold", ciphertext, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        rv0 = rv_cnt;
        fe0 = fe_cnt;
        prev = ciphertext;
        ct = rnd128();
        do_send(rnd128(), rnd128(), 1'b0);
        do_reply(ct, 3);
        repeat (2) @(negedge io_clk);
        chk("fe_count", fe_cnt - fe0, 1);
        chk("fe_rv", rv_cnt - rv0, 0);
        chk("fe_busy", busy, 0);
        chk("fe_ct_partial", ciphertext, {ct[127:104], prev[103:0]});

        rv0 = rv_cnt;
        fe0 = fe_cnt;
        ct = rnd128();
        do_send(rnd128(), rnd128(), 1'b0);
        repeat (50) @(negedge io_clk);
        io_rx = 1'b0;
        repeat (2) @(negedge io_clk);
        io_rx = 1'b1;
        repeat (50) @(negedge io_clk);
        chk("gl_busy", busy, 1);
        do_reply(ct, -1);
        chk("gl_ct", ciphertext, ct);
        chk("gl_rv", rv_cnt - rv0, 1);
        chk("gl_fe", fe_cnt - fe0, 0);

        rv0 = rv_cnt;
        fe0 = fe_cnt;
        to0 = to_cnt;
        key = rnd128();
        plaintext = rnd128();
        @(negedge io_clk) start = 1'b1;
        @(negedge io_clk) start = 1'b0;
        repeat (100 * CPB + 1) @(negedge io_clk);
        chk("rst_mid_pre_tx", io_tx, 0);
        io_reset = 1'b1;
        @(negedge io_clk);
        chk("rst_mid_tx", io_tx, 1);
        chk("rst_mid_busy", busy, 0);
        io_reset = 1'b0;
        repeat (3) @(negedge io_clk);
        chk("rst_mid_pulses", (rv_cnt - rv0) + (fe_cnt - fe0) + (to_cnt - to0), 0);
        ct = rnd128();
        do_send(rnd128(), rnd128(), 1'b0);
        do_reply(ct, -1);
        chk("rst_new_ct", ciphertext, ct);
        chk("rst_new_rv", rv_cnt - rv0, 1);

        rv0 = rv_cnt;
        ct = rnd128();
        do_send(rnd128(), rnd128(), 1'b1);
        repeat (10) @(negedge io_clk);
        start = 1'b1;
        @(negedge io_clk);
        start = 1'b0;
        chk("poke_busy", busy, 1);
        do_reply(ct, -1);
        chk("poke_ct", ciphertext, ct);
        chk("poke_rv", rv_cnt - rv0, 1);
        chk("poke_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
